// File: rtl/sqrt_req_arbiter_if.sv
// Request, response and sqrt-core signal bundle for sqrt_req_arbiter.
// slave: the arbiter side. master: requesters, response consumer and the core.
interface sqrt_req_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_operand;
    logic [NREQ-1:0]   req_ready;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [3:0]        rsp_root;
    logic [4:0]        rsp_rem;
    logic              rsp_error;

    logic              core_start;
    logic [7:0]        core_operand;
    logic              core_done;
    logic [3:0]        core_root;
    logic [4:0]        core_rem;

    modport slave (
        input  req_valid, req_operand, rsp_ready, core_done, core_root, core_rem,
        output req_ready, rsp_valid, rsp_id, rsp_root, rsp_rem, rsp_error,
               core_start, core_operand
    );

    modport master (
        output req_valid, req_operand, rsp_ready, core_done, core_root, core_rem,
        input  req_ready, rsp_valid, rsp_id, rsp_root, rsp_rem, rsp_error,
               core_start, core_operand
    );
endinterface

// File: rtl/sqrt_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative 8-bit sqrt core.
//
// state | meaning
// IDLE  | arbitrate requesters, accept one request
// ISSUE | single-cycle core_start pulse
// WAIT  | wait for core_done, timeout guard running
// RESP  | present response until consumer accepts
module sqrt_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    sqrt_req_arbiter_if.slave bus
);
    localparam int             ID_W      = $clog2(NREQ);
    localparam logic [7:0]     TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] last, id_q, grant_idx, cand;
    logic            grant_any;
    logic [NREQ-1:0] req_ready;
    logic [ID_W+2:0] op_base;
    logic [7:0]      op_q;
    logic [7:0]      timer;
    logic            core_start_q;
    logic            rsp_valid_q;
    logic            rsp_error_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [3:0]      rsp_root_q;
    logic [4:0]      rsp_rem_q;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = last + ID_W'(k);
            if (!grant_any && bus.req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign op_base = {grant_idx, 3'b000};

    // Next-state and combinational grant output.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (rst_n && grant_any) begin
                    req_ready[grant_idx] = 1'b1;
                    state_nxt            = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (bus.core_done || timer == TIMEOUT_C) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latch, start pulse, timeout timer and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last         <= ID_W'(NREQ - 1);
            id_q         <= '0;
            op_q         <= '0;
            timer        <= '0;
            core_start_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_error_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_root_q   <= '0;
            rsp_rem_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_q         <= bus.req_operand[op_base +: 8];
                        id_q         <= grant_idx;
                        last         <= grant_idx;
                        core_start_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    core_start_q <= 1'b0;
                    timer        <= '0;
                end
                WAIT: begin
                    // done wins over a timeout landing in the same cycle
                    if (bus.core_done) begin
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b0;
                        rsp_id_q    <= id_q;
                        rsp_root_q  <= bus.core_root;
                        rsp_rem_q   <= bus.core_rem;
                    end else if (timer == TIMEOUT_C) begin
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_root_q  <= '0;
                        rsp_rem_q   <= '0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.core_start   = core_start_q;
    assign bus.core_operand = op_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_error    = rsp_error_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_root     = rsp_root_q;
    assign bus.rsp_rem      = rsp_rem_q;
endmodule
